// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the feeder FSM encoding and the default data/timeout sizing.
package uart_pkg;

    localparam int DATA_W          = 8;
    localparam int TIMEOUT_DEFAULT = 65535;
    localparam int TO_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } tx_feed_state_t;

    // Occupancy counter width: must be able to represent 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous byte FIFO with a separate occupancy counter and registered flags.
// Pushes made while full are dropped and reported on a one-cycle overflow pulse.
module uart_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int LVL_W  = uart_pkg::lvl_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              full_q;
    logic              empty_q;
    logic              overflow_q;
    logic              push_ok;
    logic              pop_ok;

    // A pop in the same cycle never frees room for a push made while full.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q    <= level_d;
            full_q     <= (level_d == LVL_W'(DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= push && full_q;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system-side bytes and hands them one at a time to the UART transmitter,
// holding each byte until the transmitter reports completion or the send attempt times out.
module uart_tx_feeder import uart_pkg::*; #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    tx_feed_state_t      state_q;
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                tx_send_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                timeout_err_q;
    logic                pop;
    logic [DATA_W-1:0]   head;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    // Never start a new byte while the transmitter still claims to be active.
    assign pop = (state_q == IDLE) && !empty && !tx_active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            tx_send_q     <= 1'b0;
            tx_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= head;
                        to_cnt_q  <= '0;
                        tx_send_q <= 1'b1;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_active) begin
                        tx_send_q <= 1'b0;
                        state_q   <= WAIT_DONE;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        tx_send_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_active && tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_send_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule
